multicycle_complement: RTL and testbench

- Parametrised, multi-cycle ones'/two's complement unit for the KGP-RISC ALU datapath; covers the NOT and NEG operations.
- Processes a WIDTH-bit operand in CHUNK-bit slices, LSB slice first, one slice per clock, carrying the increment between slices.
- Start/busy/done handshake toward the ALU control FSM; result is registered and held until the next operation.

---
 rtl/multicycle_complement.sv | 145 ++++++++++++++
 tb/tb_multicycle_complement.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_complement.sv
// Multi-cycle ones'/two's complement unit (NOT / NEG) working CHUNK bits per clock, LSB slice first.
// Optional zero/ovf flag outputs are built when MULTICYCLE_COMPLEMENT_FLAGS_EN is defined.
module multicycle_complement #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [N-1:0][CHUNK-1:0]    a_q, a_d;
  logic [N-1:0][CHUNK-1:0]    result_q, result_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [CHUNK-1:0]           sum_s;
  logic                       cout_s;
  logic                       last_s;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
  logic                       mode_q, mode_d;
  logic                       zero_q, zero_d;
  logic                       ovf_q, ovf_d;
`endif

  // The slice adder sees only the currently selected operand slice and the carry chain.
  assign {cout_s, sum_s} = {1'b0, ~a_q[idx_q]} + {{CHUNK{1'b0}}, carry_q};
  assign last_s          = (idx_q == IDXW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
    mode_d   = mode_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          carry_d = mode;
          idx_d   = {IDXW{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_BUSY;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
          mode_d  = mode;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        result_d[idx_q] = sum_s;
        if (last_s) begin
          // Carry out of the top slice is dropped: arithmetic is mod 2^WIDTH.
          carry_d = 1'b0;
          idx_d   = {IDXW{1'b0}};
          done_d  = 1'b1;
          state_d = ST_DONE;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
          zero_d  = (result_d == {WIDTH{1'b0}});
          ovf_d   = mode_q & (a_q == {1'b1, {(WIDTH-1){1'b0}}});
`endif
        end else begin
          carry_d = cout_s;
          idx_d   = idx_q + IDXW'(1);
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      idx_q    <= {IDXW{1'b0}};
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
      mode_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
      mode_q   <= mode_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
  assign zero   = zero_q;
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_complement.sv
// Scoreboard bench for multicycle_complement: a 4-slice instance and a single-slice instance.
module tb_multicycle_complement;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1, mode_i;
  logic [31:0] a_i;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
  logic        zero0, ovf0, zero1, ovf1;
`endif

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done0  = 0;
  int   n_done1  = 0;
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;

  always #5 clk = ~clk;

  multicycle_complement #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode_i), .a(a_i),
    .busy(busy0), .done(done0), .result(res0)
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
    , .zero(zero0), .ovf(ovf0)
`endif
  );

  multicycle_complement #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode_i), .a(a_i),
    .busy(busy1), .done(done1), .result(res1)
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
    , .zero(zero1), .ovf(ovf1)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done0) begin
      n_done0++;
      check_eq("done0_single_cycle", prev_done0, 1'b0);
      check_eq("busy0_at_done", busy0, 1'b0);
      if (q0.size() == 0) begin
        check_eq("unexpected_done0", 1'b1, 1'b0);
      end else begin
        e = q0.pop_front();
        check_eq("result0", res0, e.r);
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
        check_eq("zero0", zero0, e.z);
        check_eq("ovf0", ovf0, e.o);
`endif
      end
    end
    if (!rst && done1) begin
      n_done1++;
      check_eq("done1_single_cycle", prev_done1, 1'b0);
      if (q1.size() == 0) begin
        check_eq("unexpected_done1", 1'b1, 1'b0);
      end else begin
        e = q1.pop_front();
        check_eq("result1", res1, e.r);
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
        check_eq("zero1", zero1, e.z);
        check_eq("ovf1", ovf1, e.o);
`endif
      end
    end
    prev_done0 = done0;
    prev_done1 = done1;
  end

  task automatic run_op(input bit sel, input logic m, input logic [31:0] val, input bit poke);
    exp_t e;
    int   n_exp;
    int   cnt;
    n_exp = sel ? 1 : 4;
    e.r = m ? (~val + 32'd1) : ~val;
    e.z = (e.r == 32'd0);
    e.o = m && (val == 32'h8000_0000);
    @(negedge clk);
    mode_i = m;
    a_i    = val;
    if (sel) begin start1 = 1'b1; q1.push_back(e); end
    else     begin start0 = 1'b1; q0.push_back(e); end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    mode_i = ~m;
    a_i    = $urandom;
    if (poke) begin
      a_i    = 32'hFFFF_FFFF;
      mode_i = 1'b0;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
    end
    cnt = 0;
    while (!(sel ? done1 : done0) && cnt < 20) begin
      check_eq("busy_while_processing", sel ? busy1 : busy0, 1'b1);
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      cnt++;
    end
    if (cnt >= 20) begin
      check_eq("done_timeout", 1'b0, 1'b1);
    end else begin
      check_eq("latency", cnt, n_exp);
      @(negedge clk);
      check_eq("done_cleared", sel ? done1 : done0, 1'b0);
      check_eq("busy_idle", sel ? busy1 : busy0, 1'b0);
      check_eq("result_held", sel ? res1 : res0, e.r);
    end
  endtask

  initial begin
    int d0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode_i = 1'b0;
    a_i    = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy0", busy0, 1'b0);
    check_eq("reset_done0", done0, 1'b0);
    check_eq("reset_result0", res0, 32'd0);
    check_eq("reset_result1", res1, 32'd0);
`ifdef MULTICYCLE_COMPLEMENT_FLAGS_EN
    check_eq("reset_zero0", zero0, 1'b0);
    check_eq("reset_ovf0", ovf0, 1'b0);
`endif
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'h0000_00FF, 1'b0);
    run_op(1'b0, 1'b1, 32'h0000_0001, 1'b0);
    run_op(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 1'b0);
    run_op(1'b0, 1'b1, 32'h0000_0000, 1'b0);
    d0 = n_done0;
    run_op(1'b0, 1'b0, 32'h0F0F_0F0F, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("ignored_start_single_done", n_done0 - d0, 1);
    check_eq("ignored_start_result", res0, 32'hF0F0_F0F0);

    // Reset after edge 2 of an operation: outputs drop without a clock.
    @(negedge clk);
    mode_i = 1'b0;
    a_i    = 32'h0F0F_0F0F;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    d0 = n_done0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_reset_busy", busy0, 1'b0);
    check_eq("async_reset_done", done0, 1'b0);
    check_eq("async_reset_result", res0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("no_done_after_abort", n_done0 - d0, 0);

    run_op(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run_op(1'b1, 1'b1, 32'h0000_0005, 1'b0);
    run_op(1'b1, 1'b0, 32'hA5A5_0000, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_op(i[0], 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    check_eq("queue0_empty", q0.size(), 0);
    check_eq("queue1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
